gate_truth_checker: RTL

GATE_TRUTH_CHECKER -- requirements
Module: gate_truth_checker

---
 rtl/gate_truth_checker.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/gate_truth_checker.sv
// ---------------------------------------------------------------------------
// gate_truth_checker
//
// Exhaustively exercises an external two-input gate by walking through the
// four input vectors (00, 01, 10, 11), giving the gate time to settle after
// each vector, and comparing its output against the function selected by
// `op`. Each sweep produces a pass/fail verdict, a mismatch count and a
// per-vector failure map.
//
// Parameters
//   SETTLE_CYC  cycles spent in SETTLE after each vector is driven (1..15)
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       begin a sweep (only honoured in IDLE or DONE)
//   op[2:0]     expected gate: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR
//   dut_a       registered input A to the gate under test
//   dut_b       registered input B to the gate under test
//   dut_y       output of the gate under test
//   busy        sweep in progress (DRIVE, SETTLE, SAMPLE)
//   done        sweep finished; held until the next start or reset
//   pass        verdict, valid while done is high
//   err_count   number of mismatching vectors in the last sweep
//   fail_vec    bit i set when vector i mismatched
//   op_err      the last latched op was illegal
//   sample_stb  one-cycle pulse during each SAMPLE cycle
// ---------------------------------------------------------------------------
module gate_truth_checker #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec,
  output logic       op_err,
  output logic       sample_stb
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  // The settle counter counts down to zero, so it is loaded with one less
  // than the number of SETTLE cycles wanted.
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYC - 1);

  // Reference behaviour of the gate selected by op.
  function automatic logic gate_fn(input logic [2:0] f, input logic a, input logic b);
    logic y;
    case (f)
      3'd0:    y = a & b;
      3'd1:    y = a | b;
      3'd2:    y = ~(a & b);
      3'd3:    y = ~(a | b);
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a ^ b);
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  // Only op codes 0..5 name a real gate.
  function automatic logic op_legal(input logic [2:0] f);
    return (f <= 3'd5);
  endfunction

  state_t     state_q,      state_d;
  logic [1:0] idx_q,        idx_d;
  logic [3:0] cnt_q,        cnt_d;
  logic [2:0] op_q,         op_d;
  logic       dut_a_q,      dut_a_d;
  logic       dut_b_q,      dut_b_d;
  logic       busy_q,       busy_d;
  logic       done_q,       done_d;
  logic       pass_q,       pass_d;
  logic [2:0] err_count_q,  err_count_d;
  logic [3:0] fail_vec_q,   fail_vec_d;
  logic       op_err_q,     op_err_d;
  logic       sample_stb_q, sample_stb_d;

  // Next-state and next-output computation for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    err_count_d = err_count_q;
    fail_vec_d  = fail_vec_q;
    op_err_d    = op_err_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          op_d        = op;
          err_count_d = 3'd0;
          fail_vec_d  = 4'b0000;
          idx_d       = 2'd0;
          cnt_d       = 4'd0;
          if (op_legal(op)) begin
            op_err_d = 1'b0;
            state_d  = ST_DRIVE;
          end else begin
            // An illegal op has no truth table to check, so report at once.
            op_err_d = 1'b1;
            state_d  = ST_DONE;
          end
        end else begin
          state_d = state_q;
        end
      end

      ST_DRIVE: begin
        cnt_d   = SETTLE_LOAD;
        state_d = ST_SETTLE;
      end

      ST_SETTLE: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        if (dut_y != gate_fn(op_q, dut_a_q, dut_b_q)) begin
          fail_vec_d[idx_q] = 1'b1;
          if (err_count_q < 3'd4) begin
            err_count_d = err_count_q + 3'd1;
          end else begin
            err_count_d = err_count_q;
          end
        end else begin
          err_count_d = err_count_q;
        end

        // Vector 11 is the last one; no wrap into a fifth vector.
        if (idx_q == 2'd3) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = ST_DRIVE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered copies derived from the upcoming state so they
    // line up with the state they describe.
    if (state_d == ST_DRIVE) begin
      dut_a_d = idx_d[1];
      dut_b_d = idx_d[0];
    end else if ((state_d == ST_IDLE) || (state_d == ST_DONE)) begin
      dut_a_d = 1'b0;
      dut_b_d = 1'b0;
    end else begin
      dut_a_d = dut_a_q;
      dut_b_d = dut_b_q;
    end

    busy_d       = (state_d == ST_DRIVE) || (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d       = (state_d == ST_DONE);
    sample_stb_d = (state_d == ST_SAMPLE);
    pass_d       = (state_d == ST_DONE) && (err_count_d == 3'd0) && !op_err_d;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      cnt_q        <= 4'd0;
      op_q         <= 3'd0;
      dut_a_q      <= 1'b0;
      dut_b_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      err_count_q  <= 3'd0;
      fail_vec_q   <= 4'b0000;
      op_err_q     <= 1'b0;
      sample_stb_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      op_q         <= op_d;
      dut_a_q      <= dut_a_d;
      dut_b_q      <= dut_b_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      err_count_q  <= err_count_d;
      fail_vec_q   <= fail_vec_d;
      op_err_q     <= op_err_d;
      sample_stb_q <= sample_stb_d;
    end
  end

  assign dut_a      = dut_a_q;
  assign dut_b      = dut_b_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_count_q;
  assign fail_vec   = fail_vec_q;
  assign op_err     = op_err_q;
  assign sample_stb = sample_stb_q;

endmodule
